// File: rtl/pattern_decoder_pkg.sv
// Shared FSM encoding and pattern-word field positions for the pattern stream decoder.
package pattern_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  function automatic int last_bit(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int newrow_bit(input int data_width);
    return data_width - 2;
  endfunction

endpackage

// File: rtl/pattern_rob.sv
// Tag-indexed reorder buffer: tags are allocated cyclically at the tail, responses land
// in their slot in any order, and words leave strictly in allocation order from the head.
module pattern_rob #(
  parameter int TAG_WIDTH  = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  alloc_i,
  input  logic                  push_i,
  input  logic [TAG_WIDTH-1:0]  push_tag_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  push_ok_o,
  output logic                  free_o,
  output logic [TAG_WIDTH-1:0]  free_tag_o,
  output logic                  head_valid_o,
  output logic [DATA_WIDTH-1:0] head_data_o
);

  localparam int DEPTH = 2 ** TAG_WIDTH;
  localparam int PTR_W = TAG_WIDTH + 1;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]      occupancy;
  logic [TAG_WIDTH-1:0]  head_tag;
  logic [DATA_WIDTH-1:0] slot_q [DEPTH];

  // A slot stays allocated from issue until decode, so the extra pointer bit marks "all in use".
  assign head_tag     = head_q[TAG_WIDTH-1:0];
  assign occupancy    = tail_q - head_q;
  assign free_o       = ~occupancy[TAG_WIDTH];
  assign free_tag_o   = tail_q[TAG_WIDTH-1:0];
  assign head_valid_o = valid_q[head_tag];
  assign head_data_o  = slot_q[head_tag];
  assign push_ok_o    = push_i && !flush_i && !valid_q[push_tag_i];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (alloc_i) tail_d = tail_q + PTR_W'(1);
      if (pop_i) begin
        valid_d[head_tag] = 1'b0;
        head_d            = head_q + PTR_W'(1);
      end
      if (push_ok_o) valid_d[push_tag_i] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // NOTE: the payload array is not reset; its valid bit gates every use of a slot's data.
  always_ff @(posedge clk) begin
    if (push_ok_o) slot_q[push_tag_i] <= push_data_i;
  end

endmodule

// File: rtl/pattern_stream_decoder.sv
// Fetches a stream of pattern words with out-of-order tagged reads and decodes them,
// in issue order, into (row, col) index entries.
module pattern_stream_decoder
  import pattern_decoder_pkg::*;
#(
  parameter int INDEX_WIDTH = 32,
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [COUNT_WIDTH-1:0] start_count,
  output logic                   req,
  output logic [TAG_WIDTH-1:0]   req_tag,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic                   req_stall,
  input  logic                   push,
  input  logic [TAG_WIDTH-1:0]   push_tag,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic                   index_push,
  input  logic                   index_stall,
  output logic [INDEX_WIDTH-1:0] row,
  output logic [INDEX_WIDTH-1:0] col,
  output logic                   busy,
  output logic                   done
);

  localparam int                    LAST_BIT   = last_bit(DATA_WIDTH);
  localparam int                    NEWROW_BIT = newrow_bit(DATA_WIDTH);
  localparam int                    OUT_W      = TAG_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d, issued_q, issued_d, decoded_q, decoded_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic [INDEX_WIDTH-1:0] acc_row_q, acc_row_d, acc_col_q, acc_col_d;
  logic [INDEX_WIDTH-1:0] row_q, row_d, col_q, col_d;
  logic                   pend_q, pend_d;

  logic                   in_run, free, head_valid, push_ok, consume, final_word, issue;
  logic                   word_unused;
  logic [TAG_WIDTH-1:0]   free_tag;
  logic [DATA_WIDTH-1:0]  head_word;
  logic [INDEX_WIDTH-1:0] delta, next_row, next_col;

  pattern_rob #(
    .TAG_WIDTH  (TAG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rob (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (!in_run),
    .alloc_i      (issue),
    .push_i       (push && in_run),
    .push_tag_i   (push_tag),
    .push_data_i  (data),
    .pop_i        (consume),
    .push_ok_o    (push_ok),
    .free_o       (free),
    .free_tag_o   (free_tag),
    .head_valid_o (head_valid),
    .head_data_o  (head_word)
  );

  assign in_run      = (state_q == ST_RUN);
  assign word_unused = ^head_word;
  assign delta       = head_word[INDEX_WIDTH-1:0];
  assign consume     = in_run && head_valid && !index_stall;
  assign final_word  = head_word[LAST_BIT] || (decoded_q + COUNT_WIDTH'(1) == count_q);
  assign next_row    = head_word[NEWROW_BIT] ? acc_row_q + INDEX_WIDTH'(1) : acc_row_q;
  assign next_col    = head_word[NEWROW_BIT] ? delta : acc_col_q + delta;

  // The terminal decode also blocks issue, so nothing is requested once the job is known to end.
  assign issue      = in_run && free && (issued_q < count_q) && !req_stall
                      && !(consume && final_word);
  assign req        = issue;
  assign req_tag    = free_tag;
  assign req_addr   = addr_q;
  assign index_push = pend_q && !index_stall;
  assign row        = row_q;
  assign col        = col_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    count_d       = count_q;
    issued_d      = issued_q;
    decoded_d     = decoded_q;
    outstanding_d = outstanding_q;
    acc_row_d     = acc_row_q;
    acc_col_d     = acc_col_q;
    row_d         = row_q;
    col_d         = col_q;
    pend_d        = pend_q && !index_push;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d        = start_addr;
          count_d       = start_count;
          issued_d      = '0;
          decoded_d     = '0;
          outstanding_d = '0;
          acc_row_d     = '0;
          acc_col_d     = '0;
          state_d       = (start_count == '0) ? ST_FINISH : ST_RUN;
        end
      end
      ST_RUN: begin
        busy          = 1'b1;
        outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(push_ok);
        if (issue) begin
          addr_d   = addr_q + WORD_BYTES;
          issued_d = issued_q + COUNT_WIDTH'(1);
        end
        if (consume) begin
          acc_row_d = next_row;
          acc_col_d = next_col;
          row_d     = next_row;
          col_d     = next_col;
          pend_d    = 1'b1;
          decoded_d = decoded_q + COUNT_WIDTH'(1);
          if (final_word) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (push && outstanding_q != '0) outstanding_d = outstanding_q - OUT_W'(1);
        // Hold done back until the final entry has actually left the output register.
        if (outstanding_q == '0 && !(pend_q && index_stall)) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      count_q       <= '0;
      issued_q      <= '0;
      decoded_q     <= '0;
      outstanding_q <= '0;
      acc_row_q     <= '0;
      acc_col_q     <= '0;
      row_q         <= '0;
      col_q         <= '0;
      pend_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      issued_q      <= issued_d;
      decoded_q     <= decoded_d;
      outstanding_q <= outstanding_d;
      acc_row_q     <= acc_row_d;
      acc_col_q     <= acc_col_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pend_q        <= pend_d;
    end
  end

endmodule
